a_sqrtb_gen: RTL and testbench
==============================

Name: a_sqrtb_gen

Overview:
Parametrised successor to the fixed 8-bit a*sqrt(b) unit. It computes y = a * floor(sqrt(b)) for unsigned W-bit operands using an iterative restoring square root followed by an iterative shift-add multiply. A mode bit returns floor(sqrt(b)) alone, skipping the multiply phase. It adds busy and overrun reporting and sits on the same single-word in_ready/y_ready handshake used by the arithmetic blocks in this design.

Parameters:
W, 8, operand width of a_in and b_in; must be even and at least 4.
YW, W + W/2, output width; fixed by W and not overridden; 12 for W=8.

Ports:
clk  in  1  system clock; rising edge active.
rst  in  1  asynchronous, active-low reset.
a_in  in  W  multiplicand, unsigned.
b_in  in  W  radicand, unsigned.
mode_in  in  1  0: y = a*floor(sqrt(b)); 1: y = floor(sqrt(b)), zero-extended.
in_ready  in  1  request strobe; sampled on each rising edge.
y_out  out  YW  result; holds its value until the next result or reset.
y_ready  out  1  one-cycle pulse marking a new y_out.
busy  out  1  high while an operation is in flight.
ovr  out  1  one-cycle pulse when in_ready is dropped because the block is busy.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. y_out=0, y_ready=0, busy=0, ovr=0. All internal registers are cleared.
- Reset mid-operation: the operation is abandoned and no y_ready is produced. After rst returns high, the block accepts in_ready on the first rising edge.
- States: IDLE, SQRT, MUL, DONE.
- IDLE: if in_ready=1 at edge k, latch a_in, b_in and mode_in, clear the root and remainder, set busy=1, go to SQRT. Operand changes after edge k have no effect.
- SQRT: W/2 cycles of restoring digit-by-digit square root. Each cycle consumes 2 bits of b, MSB pair first. The remainder is W/2+2 bits wide and the root is W/2 bits wide.
  - After the last iteration: mode=0 goes to MUL; mode=1 goes to DONE.
- MUL: W/2 cycles of shift-add, one root bit per cycle, LSB first. The accumulator is YW bits wide and cannot overflow, since (2^W-1)*(2^(W/2)-1) < 2^YW.
- DONE: one cycle. Register y_out, pulse y_ready=1, drop busy to 0, return to IDLE. Both outputs are registered.
- Latency, counted from the accepting edge k:
  - mode=0: y_ready is high in the cycle after edge k+W+1. For W=8 that is 9 edges (180 ns at a 20 ns period).
  - mode=1: y_ready is high after edge k+W/2+1.
- Throughput: in_ready is ignored in the cycle where y_ready is high, because that edge is the DONE-to-IDLE transition. The earliest accept for the next operation is one edge later.
- in_ready=1 on any edge while busy=1 or in DONE:
  - the request is dropped;
  - ovr pulses high in the following cycle;
  - the in-flight operation and its operands are unaffected.
- in_ready held high continuously: exactly one operation is accepted per IDLE visit; the other edges raise ovr.
- Boundary results:
  - b=0 gives root 0 and y=0.
  - a=0 with mode=0 gives y=0, with the same full latency.
  - Perfect squares are exact; non-squares floor.
  - Maximum for W=8: a=b=0xFF gives 0xEF1.
- y_ready never asserts without a preceding accepted in_ready. y_out never changes except when y_ready is high, or on reset.

Test Plan:
1. W=8, mode=0, a=0x19, b=0x1B, single in_ready pulse -> y_ready exactly 9 edges after accept, y_out=0x07D (25*5). Also a=0xFF, b=0xFF -> 0xEF1; a=0x64, b=0x00 -> 0x000.
2. W=8, mode=1, b=0xE1, a=0xAA -> y_out=0x00F after 5 edges; b=0xE0 -> 0x00E (floor).
3. Overrun: accept a=0x02, b=0x10, then pulse in_ready with a=0xFF, b=0xFF 3 cycles later -> ovr pulses once, y_out=0x008, no second y_ready.
4. Back-to-back: in_ready held high across two operations -> the in_ready in the y_ready cycle is dropped and raises ovr; the next edge accepts. Each result is correct and each y_ready is exactly one cycle wide.
5. Reset mid-op: drop rst for one cycle 4 cycles after accept -> y_out=0, busy=0, no y_ready. The next request a=0x03, b=0x09 -> 0x009.
6. W=16 instance: a=0xFFFF, b=0xFFFF, mode=0 -> y_out=0xFEFF01 after 17 edges; b=0x0001 -> y_out=a.

Source files
------------

// File: rtl/a_sqrtb_gen.sv
// Iterative y = a * floor(sqrt(b)): restoring square root, then shift-add multiply.
// mode_in=1 returns the root alone; busy/ovr report occupancy and dropped requests.
module a_sqrtb_gen #(
    parameter int W  = 8,
    parameter int YW = W + W / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    input  logic          mode_in,
    input  logic          in_ready,
    output logic [YW-1:0] y_out,
    output logic          y_ready,
    output logic          busy,
    output logic          ovr
);

    localparam int H  = W / 2;
    localparam int RW = H + 2;
    localparam int CW = $clog2(H + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(H - 1);
    localparam logic [CW-1:0] CNT_WB   = CW'(H);

    typedef enum logic [1:0] {IDLE, SQRT, MUL, DONE} state_t;

    state_t         state, state_nx;
    logic [YW-1:0]  a_sh;
    logic [YW-1:0]  acc;
    logic [W-1:0]   b_sh;
    logic           mode_r;
    logic [H-1:0]   root;
    logic [RW-1:0]  rem;
    logic [CW-1:0]  cnt;

    logic [RW-1:0]  rem_sh;
    logic [RW-1:0]  trial;
    logic           take;

    // One restoring-root digit: bring down the next bit pair and try subtracting 4*root+1.
    always_comb begin
        rem_sh = {rem[H-1:0], b_sh[W-1:W-2]};
        trial  = {root, 2'b01};
        take   = (rem_sh >= trial);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_ready) state_nx = SQRT;
            SQRT: begin
                if (cnt == CNT_WB)                    state_nx = DONE;
                else if (cnt == CNT_LAST && !mode_r) state_nx = MUL;
            end
            MUL:  if (cnt == CNT_WB) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // cnt == CNT_WB is a writeback cycle: the iterations are complete and the result is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sh    <= '0;
            acc     <= '0;
            b_sh    <= '0;
            mode_r  <= 1'b0;
            root    <= '0;
            rem     <= '0;
            cnt     <= '0;
            y_out   <= '0;
            y_ready <= 1'b0;
            busy    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            y_ready <= 1'b0;
            ovr     <= in_ready && (state != IDLE);
            case (state)
                IDLE: begin
                    if (in_ready) begin
                        a_sh   <= YW'(a_in);
                        b_sh   <= b_in;
                        mode_r <= mode_in;
                        root   <= '0;
                        rem    <= '0;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                SQRT: begin
                    if (cnt == CNT_WB) begin
                        y_out   <= YW'(root);
                        y_ready <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        b_sh <= b_sh << 2;
                        rem  <= take ? (rem_sh - trial) : rem_sh;
                        root <= {root[H-2:0], take};
                        if (cnt == CNT_LAST && !mode_r) cnt <= '0;
                        else                            cnt <= cnt + 1'b1;
                    end
                end
                MUL: begin
                    if (cnt == CNT_WB) begin
                        y_out   <= acc;
                        y_ready <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        if (root[0]) acc <= acc + a_sh;
                        a_sh <= a_sh << 1;
                        root <= root >> 1;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_a_sqrtb_gen.sv
// Scenario bench for a_sqrtb_gen: W=8 and W=16 instances, queued expected results.
module tb_a_sqrtb_gen;

    logic        clk;
    logic        rst;

    logic [7:0]  a8, b8;
    logic        mode8, in_ready8;
    logic [11:0] y8;
    logic        yr8, busy8, ovr8;

    logic [15:0] a16, b16;
    logic        mode16, in_ready16;
    logic [23:0] y16;
    logic        yr16, busy16, ovr16;

    int n_tests = 0;
    int n_fail  = 0;

    longint q8[$];
    longint q16[$];

    a_sqrtb_gen #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .a_in(a8), .b_in(b8), .mode_in(mode8),
        .in_ready(in_ready8), .y_out(y8), .y_ready(yr8), .busy(busy8), .ovr(ovr8)
    );

    a_sqrtb_gen #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .a_in(a16), .b_in(b16), .mode_in(mode16),
        .in_ready(in_ready16), .y_out(y16), .y_ready(yr16), .busy(busy16), .ovr(ovr16)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic longint model(longint a, longint b, bit mode);
        longint r = 0;
        while ((r + 1) * (r + 1) <= b) r++;
        return mode ? r : a * r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic m);
        a8 = a; b8 = b; mode8 = m; in_ready8 = 1'b1;
        tick();
        in_ready8 = 1'b0;
    endtask

    task automatic wait8(output int lat, output logic [11:0] y, output bit ok);
        ok = 0; lat = 0; y = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (yr8 === 1'b1) begin
                lat = i; y = y8; ok = 1;
                break;
            end
        end
    endtask

    task automatic wait16(output int lat, output logic [23:0] y, output bit ok);
        ok = 0; lat = 0; y = '0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (yr16 === 1'b1) begin
                lat = i; y = y16; ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a8 = '0; b8 = '0; mode8 = 1'b0; in_ready8 = 1'b0;
        a16 = '0; b16 = '0; mode16 = 1'b0; in_ready16 = 1'b0;
        #2 rst = 1'b0;
        #3;
        n_tests++; if (y8 !== 12'h000) begin n_fail++; $display("FAIL reset_y got=%h want=000", y8); end
        n_tests++; if (yr8 !== 1'b0)   begin n_fail++; $display("FAIL reset_y_ready got=%b want=0", yr8); end
        n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy8); end
        n_tests++; if (ovr8 !== 1'b0)  begin n_fail++; $display("FAIL reset_ovr got=%b want=0", ovr8); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_mode0();
        logic [7:0]  ta [3] = '{8'h19, 8'hFF, 8'h64};
        logic [7:0]  tb [3] = '{8'h1B, 8'hFF, 8'h00};
        int lat; logic [11:0] y; bit ok; longint e;
        for (int i = 0; i < 3; i++) begin
            q8.push_back(model(ta[i], tb[i], 1'b0));
            start8(ta[i], tb[i], 1'b0);
            if (i == 0) begin
                n_tests++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL m0_busy got=%b want=1", busy8); end
            end
            wait8(lat, y, ok);
            e = q8.pop_front();
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL m0_timeout vec=%0d no y_ready within 40 edges", i); end
            else if (longint'(y) !== e) begin n_fail++; $display("FAIL m0_y vec=%0d got=%h want=%h", i, y, e); end
            n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL m0_latency vec=%0d got=%0d want=9", i, lat); end
            tick();
        end
    endtask

    task automatic test_mode1();
        logic [7:0] tb [2] = '{8'hE1, 8'hE0};
        int lat; logic [11:0] y; bit ok; longint e;
        for (int i = 0; i < 2; i++) begin
            q8.push_back(model(8'hAA, tb[i], 1'b1));
            start8(8'hAA, tb[i], 1'b1);
            wait8(lat, y, ok);
            e = q8.pop_front();
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL m1_timeout vec=%0d no y_ready", i); end
            else if (longint'(y) !== e) begin n_fail++; $display("FAIL m1_y vec=%0d got=%h want=%h", i, y, e); end
            n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL m1_latency vec=%0d got=%0d want=5", i, lat); end
            tick();
        end
    endtask

    task automatic test_overrun();
        int n_ovr = 0; int n_yr = 0; logic [11:0] y = '0; longint e;
        q8.push_back(model(8'h02, 8'h10, 1'b0));
        start8(8'h02, 8'h10, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            if (ovr8 === 1'b1) n_ovr++;
        end
        a8 = 8'hFF; b8 = 8'hFF; in_ready8 = 1'b1;
        tick();
        in_ready8 = 1'b0;
        n_tests++; if (ovr8 !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got=%b want=1", ovr8); end
        if (ovr8 === 1'b1) n_ovr++;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ovr8 === 1'b1) n_ovr++;
            if (yr8 === 1'b1) begin n_yr++; y = y8; end
        end
        e = q8.pop_front();
        n_tests++; if (longint'(y) !== e) begin n_fail++; $display("FAIL ovr_y got=%h want=%h", y, e); end
        n_tests++; if (n_yr !== 1) begin n_fail++; $display("FAIL ovr_y_ready_count got=%0d want=1", n_yr); end
        n_tests++; if (n_ovr !== 1) begin n_fail++; $display("FAIL ovr_count got=%0d want=1", n_ovr); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [11:0] y; bit ok; longint e;
        q8.push_back(model(8'h19, 8'h1B, 1'b0));
        q8.push_back(model(8'h03, 8'h09, 1'b0));
        a8 = 8'h19; b8 = 8'h1B; mode8 = 1'b0; in_ready8 = 1'b1;
        tick();
        a8 = 8'h03; b8 = 8'h09;
        wait8(lat, y, ok);
        e = q8.pop_front();
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL b2b_first_timeout no y_ready"); end
        else if (longint'(y) !== e) begin n_fail++; $display("FAIL b2b_first_y got=%h want=%h", y, e); end
        n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL b2b_first_latency got=%0d want=9", lat); end
        tick();
        n_tests++; if (yr8 !== 1'b0)  begin n_fail++; $display("FAIL b2b_pulse_width got=%b want=0", yr8); end
        n_tests++; if (ovr8 !== 1'b1) begin n_fail++; $display("FAIL b2b_done_ovr got=%b want=1", ovr8); end
        n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL b2b_done_busy got=%b want=0", busy8); end
        tick();
        n_tests++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy got=%b want=1", busy8); end
        n_tests++; if (ovr8 !== 1'b0)  begin n_fail++; $display("FAIL b2b_accept_ovr got=%b want=0", ovr8); end
        wait8(lat, y, ok);
        in_ready8 = 1'b0;
        e = q8.pop_front();
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL b2b_second_timeout no y_ready"); end
        else if (longint'(y) !== e) begin n_fail++; $display("FAIL b2b_second_y got=%h want=%h", y, e); end
        n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL b2b_second_latency got=%0d want=9", lat); end
        tick();
        n_tests++; if (yr8 !== 1'b0) begin n_fail++; $display("FAIL b2b_second_width got=%b want=0", yr8); end
        tick();
    endtask

    task automatic test_reset_midop();
        bit seen = 0; int lat; logic [11:0] y; bit ok; longint e;
        start8(8'h55, 8'h80, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        #1;
        n_tests++; if (y8 !== 12'h000) begin n_fail++; $display("FAIL rmid_y got=%h want=000", y8); end
        n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b want=0", busy8); end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (yr8 === 1'b1) seen = 1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_spurious_y_ready got=%b want=0", seen); end
        q8.push_back(model(8'h03, 8'h09, 1'b0));
        start8(8'h03, 8'h09, 1'b0);
        wait8(lat, y, ok);
        e = q8.pop_front();
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rmid_after_timeout no y_ready"); end
        else if (longint'(y) !== e) begin n_fail++; $display("FAIL rmid_after_y got=%h want=%h", y, e); end
        tick();
    endtask

    task automatic test_w16();
        logic [15:0] ta [3] = '{16'hFFFF, 16'h1234, 16'hBEEF};
        logic [15:0] tb [3] = '{16'hFFFF, 16'h0001, 16'h2710};
        int lat; logic [23:0] y; bit ok; longint e;
        for (int i = 0; i < 3; i++) begin
            q16.push_back(model(ta[i], tb[i], 1'b0));
            a16 = ta[i]; b16 = tb[i]; mode16 = 1'b0; in_ready16 = 1'b1;
            tick();
            in_ready16 = 1'b0;
            wait16(lat, y, ok);
            e = q16.pop_front();
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL w16_timeout vec=%0d no y_ready", i); end
            else if (longint'(y) !== e) begin n_fail++; $display("FAIL w16_y vec=%0d got=%h want=%h", i, y, e); end
            n_tests++; if (lat !== 17) begin n_fail++; $display("FAIL w16_latency vec=%0d got=%0d want=17", i, lat); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_overrun();
        test_back_to_back();
        test_reset_midop();
        test_w16();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
